// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared seven-segment display types, constants and leading-blank mask
package seven_seg_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, HANDOFF} disp_arb_state_t;

    localparam int NUM_DIGITS = 8;
    localparam int DIGIT_W    = 4;

    // Digit k (k>=1) is blank when it and every more significant digit are zero.
    function automatic logic [NUM_DIGITS-1:0] lead_blank_mask(
        input logic [NUM_DIGITS*DIGIT_W-1:0] v
    );
        logic                  zero_run;
        logic [NUM_DIGITS-1:0] mask;
        zero_run = 1'b1;
        mask     = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run && (v[k*DIGIT_W +: DIGIT_W] == '0);
            mask[k]  = zero_run;
        end
        return mask;
    endfunction

endpackage

// File: rtl/seven_seg_display_arbiter_rr_pick.sv
// rtl/seven_seg_display_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick #(
    parameter int N = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    int               j;
    logic [IDX_W-1:0] cand;

    // Scan from ptr upward with wrap; the first requester found wins.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        j      = 0;
        cand   = '0;
        for (int off = 0; off < N; off++) begin
            j = int'(ptr) + off;
            if (j >= N) begin
                j = j - N;
            end
            cand = IDX_W'(j);
            if (!any && req[cand]) begin
                any          = 1'b1;
                idx          = cand;
                onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_display_arbiter.sv
// rtl/seven_seg_display_arbiter.sv - round-robin owner arbitration of the shared 8-digit display
module seven_seg_display_arbiter
    import seven_seg_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int DWELL_CYCLES    = 100_000_000,
    parameter int MAX_LOCK_DWELLS = 4,
    parameter int LEAD_BLANK      = 1,
    localparam int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [NUM_REQ-1:0]    req_in,
    input  logic [NUM_REQ-1:0]    lock_in,
    input  logic [NUM_REQ*32-1:0] val_in,
    output logic [31:0]           val_out,
    output logic [NUM_DIGITS-1:0] blank_out,
    output logic [NUM_REQ-1:0]    grant_out,
    output logic [IDX_W-1:0]      owner_out,
    output logic                  switch_out
);

    localparam logic [31:0]           DWELL_LAST = 32'(DWELL_CYCLES - 1);
    localparam logic [31:0]           LOCK_LIMIT = 32'(MAX_LOCK_DWELLS - 1);
    localparam logic [NUM_DIGITS-1:0] ALL_BLANK  = '1;

    disp_arb_state_t       state_q;
    logic [31:0]           val_q;
    logic [NUM_DIGITS-1:0] blank_q;
    logic [NUM_REQ-1:0]    grant_q;
    logic [IDX_W-1:0]      owner_q;
    logic                  switch_q;
    logic [IDX_W-1:0]      ptr_q;
    logic [31:0]           dwell_q;
    logic [31:0]           lock_q;

    logic [IDX_W-1:0]      next_ptr;
    logic [IDX_W-1:0]      pick_ptr;
    logic                  pick_any;
    logic [IDX_W-1:0]      pick_idx;
    logic [NUM_REQ-1:0]    pick_onehot;
    logic [31:0]           owner_val;
    logic [NUM_DIGITS-1:0] hold_blank;
    logic                  expiry;
    logic                  others_req;

    assign next_ptr   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    // In HANDOFF the old owner drops to lowest priority in the very cycle it releases.
    assign pick_ptr   = (state_q == HANDOFF) ? next_ptr : ptr_q;
    assign owner_val  = val_in[{owner_q, 5'b0} +: 32];
    assign hold_blank = (LEAD_BLANK != 0) ? lead_blank_mask(owner_val) : '0;
    assign expiry     = (dwell_q == DWELL_LAST);
    assign others_req = |(req_in & ~grant_q);

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req    (req_in),
        .ptr    (pick_ptr),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            val_q    <= '0;
            blank_q  <= ALL_BLANK;
            grant_q  <= '0;
            owner_q  <= '0;
            switch_q <= 1'b0;
            ptr_q    <= '0;
            dwell_q  <= '0;
            lock_q   <= '0;
        end else begin
            switch_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    blank_q <= ALL_BLANK;
                    grant_q <= '0;
                    if (pick_any) begin
                        state_q  <= HOLD;
                        grant_q  <= pick_onehot;
                        owner_q  <= pick_idx;
                        switch_q <= 1'b1;
                        dwell_q  <= '0;
                        lock_q   <= '0;
                    end
                end
                HOLD: begin
                    val_q   <= owner_val;
                    blank_q <= hold_blank;
                    dwell_q <= expiry ? '0 : dwell_q + 32'd1;
                    // A dropped request wins over a simultaneous expiry.
                    if (!req_in[owner_q]) begin
                        state_q <= HANDOFF;
                        grant_q <= '0;
                        blank_q <= ALL_BLANK;
                    end else if (expiry) begin
                        if (!others_req) begin
                            lock_q <= '0;
                        end else if (lock_in[owner_q] && (lock_q < LOCK_LIMIT)) begin
                            lock_q <= lock_q + 32'd1;
                        end else begin
                            state_q <= HANDOFF;
                            grant_q <= '0;
                            blank_q <= ALL_BLANK;
                        end
                    end
                end
                HANDOFF: begin
                    ptr_q <= next_ptr;
                    if (pick_any) begin
                        state_q  <= HOLD;
                        grant_q  <= pick_onehot;
                        owner_q  <= pick_idx;
                        switch_q <= 1'b1;
                        dwell_q  <= '0;
                        lock_q   <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign val_out    = val_q;
    assign blank_out  = blank_q;
    assign grant_out  = grant_q;
    assign owner_out  = owner_q;
    assign switch_out = switch_q;

endmodule

// File: tb/tb_seven_seg_display_arbiter.sv
// tb/tb_seven_seg_display_arbiter.sv - directed and randomized check of the display arbiter
module tb_seven_seg_display_arbiter;

    localparam int N  = 4;
    localparam int DW = 10;
    localparam int ML = 2;

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic [3:0]   req_in;
    logic [3:0]   lock_in;
    logic [127:0] val_in;
    logic [31:0]  val_out;
    logic [7:0]   blank_out;
    logic [3:0]   grant_out;
    logic [1:0]   owner_out;
    logic         switch_out;

    seven_seg_display_arbiter #(
        .NUM_REQ(N), .DWELL_CYCLES(DW), .MAX_LOCK_DWELLS(ML), .LEAD_BLANK(1)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .req_in(req_in), .lock_in(lock_in),
        .val_in(val_in), .val_out(val_out), .blank_out(blank_out),
        .grant_out(grant_out), .owner_out(owner_out), .switch_out(switch_out)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int miscompares = 0;

    // Reference: mode 0 = nobody shown, 1 = owner shown, 2 = blank gap between owners.
    int          m_mode, m_owner, m_ptr, m_tenure, m_ext;
    logic [31:0] e_val;
    logic [7:0]  e_blank;
    logic [3:0]  e_grant;
    logic        e_switch;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_blank(input logic [31:0] v);
        int top_nz = 0;
        logic [7:0] b = '0;
        for (int k = 0; k < 8; k++)
            if (((v >> (4 * k)) & 32'hF) != 0) top_nz = k;
        for (int k = 1; k < 8; k++)
            if (k > top_nz) b[k] = 1'b1;
        return b;
    endfunction

    function automatic int pick(input logic [3:0] r, input int start);
        for (int off = 0; off < N; off++)
            if (r[(start + off) % N]) return (start + off) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_owner = 0; m_ptr = 0; m_tenure = 0; m_ext = 0;
        e_val = '0; e_blank = 8'hFF; e_grant = '0; e_switch = 1'b0;
    endtask

    task automatic model_grant(input int w);
        m_mode = 1; m_owner = w; e_grant = 4'b0001 << w; e_switch = 1'b1;
        m_tenure = 0; m_ext = 0;
    endtask

    task automatic model_clock();
        int w;
        bit leave, dwell_end, contended;
        e_switch = 1'b0;
        case (m_mode)
            0: begin
                w = pick(req_in, m_ptr);
                if (w >= 0) model_grant(w);
            end
            1: begin
                e_val     = val_in[32*m_owner +: 32];
                dwell_end = ((m_tenure + 1) % DW) == 0;
                contended = (req_in & ~(4'b0001 << m_owner)) != 0;
                leave     = 0;
                if (!req_in[m_owner]) leave = 1;
                else if (dwell_end && !contended) m_ext = 0;
                else if (dwell_end && lock_in[m_owner] && m_ext < ML - 1) m_ext++;
                else if (dwell_end) leave = 1;
                m_tenure++;
                if (leave) begin
                    m_mode = 2; e_grant = '0; e_blank = 8'hFF;
                end else begin
                    e_blank = ref_blank(e_val);
                end
            end
            default: begin
                m_ptr = (m_owner + 1) % N;
                w = pick(req_in, m_ptr);
                if (w >= 0) model_grant(w);
                else m_mode = 0;
            end
        endcase
    endtask

    task automatic check_all();
        chk("grant", 32'(grant_out), 32'(e_grant));
        chk("owner", 32'(owner_out), 32'(m_owner));
        chk("switch", 32'(switch_out), 32'(e_switch));
        chk("blank", 32'(blank_out), 32'(e_blank));
        chk("val", val_out, e_val);
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] l);
        req_in = r;
        lock_in = l;
        @(posedge clk_in);
        model_clock();
        #1;
        check_all();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_blank"}, 32'(blank_out), 32'hFF);
        chk({tag, "_grant"}, 32'(grant_out), 32'h0);
        chk({tag, "_val"}, val_out, 32'h0);
        chk({tag, "_owner"}, 32'(owner_out), 32'h0);
        chk({tag, "_switch"}, 32'(switch_out), 32'h0);
    endtask

    task automatic apply_reset();
        rst_n_in = 1'b0;
        req_in = '0;
        lock_in = '0;
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        model_reset();
    endtask

    initial begin
        int seq[$];
        int exp_seq[5];
        int held, waited;
        logic [3:0] r, l;
        logic [31:0] v;

        val_in = '0;
        apply_reset();
        check_reset_values("rst");
        for (int i = 0; i < 4; i++) step(4'b0000, 4'b0000);

        // Single requester with a small value: leading digits blank, digit 0 never.
        val_in[63:32] = 32'h0000_00A5;
        step(4'b0010, 4'b0000);
        chk("first_grant", 32'(grant_out), 32'h2);
        chk("first_switch", 32'(switch_out), 32'h1);
        step(4'b0010, 4'b0000);
        chk("a5_val", val_out, 32'hA5);
        chk("a5_blank", 32'(blank_out), 32'hFC);
        for (int i = 0; i < 3; i++) step(4'b0010, 4'b0000);

        // All requesting: strict rotation 0,1,2,3,0.
        apply_reset();
        for (int i = 0; i < N; i++) val_in[32*i +: 32] = $urandom;
        for (int i = 0; i < 60; i++) begin
            step(4'b1111, 4'b0000);
            if (switch_out) seq.push_back(int'(owner_out));
        end
        exp_seq = '{0, 1, 2, 3, 0};
        chk("rr_count_ok", 32'(seq.size() >= 5), 32'h1);
        for (int i = 0; i < 5 && i < seq.size(); i++) chk("rr_order", 32'(seq[i]), 32'(exp_seq[i]));

        // Locked owner 0 holds two dwells while requester 2 waits.
        apply_reset();
        held = 0;
        waited = 0;
        while (grant_out != 4'b0100 && waited < 40) begin
            step(4'b0101, 4'b0001);
            if (grant_out == 4'b0001) held++;
            waited++;
        end
        chk("lock_hold_cycles", 32'(held), 32'd20);
        chk("lock_next_owner", 32'(owner_out), 32'd2);

        // Owner 1 drops mid-dwell with requester 3 pending.
        apply_reset();
        step(4'b0010, 4'b0000);
        for (int i = 0; i < 3; i++) step(4'b1010, 4'b0000);
        step(4'b1000, 4'b0000);
        chk("drop_gap_grant", 32'(grant_out), 32'h0);
        chk("drop_gap_blank", 32'(blank_out), 32'hFF);
        step(4'b1000, 4'b0000);
        chk("drop_new_grant", 32'(grant_out), 32'h8);
        for (int i = 0; i < 3; i++) step(4'b1000, 4'b0000);

        // Asynchronous reset in the middle of a hold.
        #2;
        rst_n_in = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        model_reset();

        // Randomized traffic with sticky requests so dwells actually expire.
        r = 4'($urandom);
        l = 4'($urandom);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) r = 4'($urandom);
            if ($urandom_range(0, 5) == 0) l = 4'($urandom);
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    v = $urandom;
                    v = v >> $urandom_range(0, 32);
                    val_in[32*k +: 32] = v;
                end
            end
            step(r, l);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
